sbox_seq_ctrl: RTL
==================

// Module: sbox_seq_ctrl
// PURPOSE
//  Sequencer that time-shares a single muxed DES S-box bank across the eight 6-bit groups of a
//  48-bit round-function word (post key-XOR). Accepts one 48-bit word per transaction, drives one
//  lookup per cycle (box 1..8), and packs the eight 4-bit results into a 32-bit word for the P-permutation.
//  Sits between the key-mixing stage and the permutation stage of the iterative DES round.
// PARAMETERS
//  NUM_BOX   8  number of S-box lookups per word; fixed at 8 for DES, other values unsupported
//  IDX_W     3  width of box index / lookup counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream word available
//  in_ready   out  1      block can accept a word (high only in IDLE)
//  data_in    in   [1:48] 48-bit word; bit 1 = MSB; group k = bits [6k-5:6k]
//  sbox_sel   out  [2:0]  box select to the shared bank: 0 = S1 ... 7 = S8
//  sbox_in    out  [1:6]  6-bit group sent to the bank
//  sbox_out   in   [1:4]  bank result, combinational, same cycle as sbox_sel/sbox_in
//  out_valid  out  1      packed result valid
//  out_ready  in   1      downstream accepts the result
//  data_out   out  [1:32] packed result; nibble k (S(k)) at bits [4k-3:4k]
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset: state = IDLE; in_ready = 1 (combinational from state); out_valid = 0; busy = 0;
//   sbox_sel = 0; sbox_in = 0; data_out = 0; counter = 0; internal 48-bit capture reg = 0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready = 1. On in_valid (handshake), capture data_in, clear counter and data_out.
//   Next state is RUN.
//  RUN: in_ready = 0. Each cycle:
//   - sbox_sel = counter; sbox_in = captured group counter+1.
//   - sbox_out is written into nibble counter+1 of data_out at the clock edge; counter increments.
//   - After the lookup with counter = 7, next state is DONE and counter wraps to 0.
//  Lookups are strictly in order S1..S8, exactly one per cycle, with no bubbles.
//  sbox_sel/sbox_in are registered-state-driven (from counter and capture reg).
//   They hold 0 outside RUN.
//  DONE: out_valid = 1; data_out is stable. On out_ready, next state is IDLE and out_valid drops
//   on the next cycle. If out_ready is low, hold indefinitely (data_out, out_valid unchanged).
//  Latency: handshake at edge N; RUN spans edges N+1..N+8; out_valid is high from edge N+8.
//   Earliest new accept is the edge after out_ready. Throughput is 1 word per 10 cycles minimum.
//  No overlap: a new word is never accepted while in RUN or DONE.
//   in_valid in those states is ignored, not queued.
//  data_in changes after the handshake have no effect (captured copy used).
//  sbox_out is sampled only in RUN; values in other states are ignored.
//  rst asserted in any state (incl. mid-RUN or DONE with out_ready low): next edge restores all
//   reset values. The partial result is discarded and no out_valid pulse is produced.
//  in_valid and rst high together: reset wins, word not captured.
// TESTING
//  T1 zeros: reset, send data_in = 48'h0, real S1..S8 bank, out_ready = 1 ->
//   out_valid 8 cycles after accept, data_out = 32'hEFA72C4D.
//  T2 ones: data_in = 48'hFFFF_FFFF_FFFF -> data_out = 32'hD9CE3DCB;
//   sbox_sel steps 0..7 on consecutive cycles with sbox_in = 6'h3F each cycle.
//  T3 backpressure: T1 with out_ready low 20 cycles ->
//   out_valid/data_out held at 32'hEFA72C4D, in_ready = 0 throughout.
//   Accept only after out_ready pulse plus one cycle.
//  T4 ignored input: toggle in_valid and data_in during RUN ->
//   result still matches the captured word, and exactly one out_valid transaction occurs.
//  T5 reset mid-RUN: rst high at lookup 4 ->
//   next cycle in IDLE, in_ready = 1, out_valid = 0, data_out = 0.
//   A following 48'h0 transaction yields 32'hEFA72C4D.
//  T6 back-to-back: two words with in_valid held and out_ready = 1 ->
//   second accept exactly 10 cycles after first, both results correct.

Source files
------------

// File: rtl/sbox_seq_ctrl.sv
// sbox_seq_ctrl: time-shares one DES S-box bank over the eight 6-bit groups of a word, packing a 32-bit result
module sbox_seq_ctrl #(
    parameter int NUM_BOX = 8,
    parameter int IDX_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] data_in,
    output logic [2:0]  sbox_sel,
    output logic [1:6]  sbox_in,
    input  logic [1:4]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] data_out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] cnt;
    logic [1:48] cap;
    logic last;
    assign last = cnt == IDX_W'(NUM_BOX - 1);
    always_comb begin
        state_nx  = (state == IDLE && in_valid)  ? RUN  :
                    (state == RUN  && last)      ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        sbox_sel  = state == RUN ? 3'(cnt) : '0;
        // group cnt+1 sits 42-6*cnt bits above the LSB of the captured word
        sbox_in   = state == RUN ? 6'(cap >> (6'd42 - 6'(cnt) * 6'd6)) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap      <= '0;
            data_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                cap      <= data_in;
                cnt      <= '0;
                data_out <= '0;
            end else if (state == RUN) begin
                data_out <= data_out | ({sbox_out, 28'b0} >> {cnt, 2'b00});
                cnt      <= last ? '0 : cnt + IDX_W'(1);
            end
        end
    end
endmodule
